// File: rtl/seq_fixed_div_pkg.sv
// seq_fixed_div_pkg: fixed-point format constants and divider state encoding
package seq_fixed_div_pkg;
  localparam int FixedPointPrecision = 16;
  localparam int FixedPointFracBits = 8;
  typedef logic signed [FixedPointPrecision-1:0] fixed_point_t;
  localparam fixed_point_t FixedPointMin = {1'b1, {(FixedPointPrecision-1){1'b0}}};
  localparam fixed_point_t FixedPointMax = {1'b0, {(FixedPointPrecision-1){1'b1}}};
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_e;
endpackage

// File: rtl/seq_fixed_div_if.sv
// seq_fixed_div_if: operand/result handshake bundle; status_o exists only with SEQ_FIXED_DIV_STATUS_EN
interface seq_fixed_div_if #(parameter int Width = 16) ();
  logic             in_valid_i;
  logic             in_ready_o;
  logic [Width-1:0] a_i;
  logic [Width-1:0] b_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [Width-1:0] y_o;
`ifdef SEQ_FIXED_DIV_STATUS_EN
  logic [1:0]       status_o;
`endif
  modport slave (
`ifdef SEQ_FIXED_DIV_STATUS_EN
    output status_o,
`endif
    input  in_valid_i, a_i, b_i, out_ready_i,
    output in_ready_o, out_valid_o, y_o
  );
  modport master (
`ifdef SEQ_FIXED_DIV_STATUS_EN
    input  status_o,
`endif
    output in_valid_i, a_i, b_i, out_ready_i,
    input  in_ready_o, out_valid_o, y_o
  );
endinterface

// File: rtl/seq_fixed_div_core.sv
// seq_fixed_div_core: unsigned radix-2 restoring divider, one quotient bit per clock
module seq_fixed_div_core #(
  parameter int W = 16,
  parameter int N = 24
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient
);
  localparam int CW = $clog2(N + 1);
  logic [N-1:0]  dvd, q, cur_dvd;
  logic [W-1:0]  dvs, rem, cur_dvs, cur_rem;
  logic [CW-1:0] cnt;
  logic [W:0]    rem_sh;
  logic          ge;
  // The first iteration runs on the start edge straight from the inputs.
  assign cur_dvd  = start ? dividend : dvd;
  assign cur_dvs  = start ? divisor : dvs;
  assign cur_rem  = start ? '0 : rem;
  assign rem_sh   = {cur_rem, cur_dvd[N-1]};
  assign ge       = rem_sh >= {1'b0, cur_dvs};
  assign done     = busy && cnt == CW'(N - 1);
  assign quotient = q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy <= 1'b0;
      cnt  <= '0;
      dvd  <= '0;
      dvs  <= '0;
      rem  <= '0;
      q    <= '0;
    end else if (start || busy) begin
      busy <= start || !done;
      cnt  <= start ? CW'(1) : cnt + CW'(1);
      dvd  <= cur_dvd << 1;
      dvs  <= cur_dvs;
      rem  <= ge ? W'(rem_sh - {1'b0, cur_dvs}) : rem_sh[W-1:0];
      q    <= start ? N'(ge) : {q[N-2:0], ge};
    end
  end
endmodule

// File: rtl/seq_fixed_div.sv
// seq_fixed_div: signed fixed-point divider y = a / b with sign fix-up, saturation and valid/ready
// SEQ_FIXED_DIV_STATUS_EN adds status_o = {div_by_zero, saturated}.
module seq_fixed_div
  import seq_fixed_div_pkg::*;
#(
  parameter int Width    = FixedPointPrecision,
  parameter int FracBits = FixedPointFracBits
) (
  input logic            clk_i,
  input logic            rst_ni,
  seq_fixed_div_if.slave io
);
  localparam int N = Width + FracBits;
  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_CALC = CALC;
  localparam logic [1:0] S_FIX  = FIX;
  localparam logic [1:0] S_DONE = DONE;
  localparam logic [Width-1:0] MAX = {1'b0, {(Width-1){1'b1}}};
  localparam logic [Width-1:0] MIN = {1'b1, {(Width-1){1'b0}}};
  localparam logic [N-1:0] Q_LIM = N'(1) << (Width - 1);
  logic [1:0]       state;
  logic             sign, accept, start, a_zero, b_zero, sat_fix;
  logic             core_busy, core_done;
  logic [Width-1:0] abs_a, abs_b, y, y_zero_div, y_fix, q_lo;
  logic [N-1:0]     q, dividend;
  assign io.in_ready_o  = state == S_IDLE && !core_busy;
  assign io.out_valid_o = state == S_DONE;
  assign io.y_o         = y;
  assign accept     = io.in_valid_i && io.in_ready_o;
  assign a_zero     = io.a_i == '0;
  assign b_zero     = io.b_i == '0;
  assign start      = accept && !b_zero;
  assign abs_a      = io.a_i[Width-1] ? -io.a_i : io.a_i;
  assign abs_b      = io.b_i[Width-1] ? -io.b_i : io.b_i;
  assign dividend   = N'(abs_a) << FracBits;
  assign y_zero_div = a_zero ? '0 : io.a_i[Width-1] ? MIN : MAX;
  // Positive results clamp above 2^(W-1)-1 and negative ones at 2^(W-1): both mean q >= 2^(W-1).
  assign q_lo       = q[Width-1:0];
  assign sat_fix    = q >= Q_LIM;
  assign y_fix      = sat_fix ? (sign ? MIN : MAX) : sign ? -q_lo : q_lo;
  seq_fixed_div_core #(.W(Width), .N(N)) u_core (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .start    (start),
    .dividend (dividend),
    .divisor  (abs_b),
    .busy     (core_busy),
    .done     (core_done),
    .quotient (q)
  );
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= S_IDLE;
      sign  <= 1'b0;
      y     <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          sign  <= io.a_i[Width-1] ^ io.b_i[Width-1];
          state <= b_zero ? S_DONE : S_CALC;
          if (b_zero) y <= y_zero_div;
        end
        S_CALC: if (core_done) state <= S_FIX;
        S_FIX: begin
          y     <= y_fix;
          state <= S_DONE;
        end
        default: if (io.out_ready_i) state <= S_IDLE;
      endcase
    end
  end
`ifdef SEQ_FIXED_DIV_STATUS_EN
  logic [1:0] status;
  assign io.status_o = status;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) status <= '0;
    else if (accept && b_zero) status <= {!a_zero, !a_zero};
    else if (state == S_FIX) status <= {1'b0, sat_fix};
  end
`endif
endmodule

// File: doc/seq_fixed_div.md
Name: seq_fixed_div

Overview:
- Multi-cycle signed fixed-point divider, y = a / b. One quotient bit per clock (radix-2 restoring) on operand magnitudes, followed by sign fix-up and saturation.
- Width and fraction bits are parameters. The block is shared per row by the row-normalisation stage of the ternary matmul AFU.
- Valid/ready handshake on both input and output, so upstream and downstream stall safely.

Parameters:
- Width, 16: total fixed-point bits (two's complement).
- FracBits, 8: fractional bits. Legal range 0 <= FracBits < Width. The top level binds Width/FracBits from config_pkg.
- N (localparam), Width+FracBits: number of iterations.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- in_valid_i  in  1  operands valid.
- in_ready_o  out  1  block can accept operands.
- a_i  in  Width  dividend, signed fixed-point.
- b_i  in  Width  divisor, signed fixed-point.
- out_valid_o  out  1  quotient valid.
- out_ready_i  in  1  downstream accepts quotient.
- y_o  out  Width  quotient, signed fixed-point.

Behaviour:
- Reset (async, rst_ni low): state IDLE; out_valid_o=0; y_o=0; counter=0; in_ready_o=1 once reset is released.
  - Reset asserted mid-CALC or mid-DONE aborts the operation. No output is produced.
- IDLE:
  - in_ready_o=1.
  - Accept on in_valid_i&&in_ready_o: latch |a|, |b|, sign = a[W-1]^b[W-1], a_zero, b_zero.
  - If b_i==0: go to DONE and load y: a<0 -> Min (1 followed by 0s), a>0 -> Max (0 followed by 1s), a==0 -> 0. out_valid_o is high after 1 edge.
  - Otherwise go to CALC with counter=0.
- CALC:
  - Dividend = |a| << FracBits, N bits, unsigned. Divisor = |b|, Width bits.
  - Each edge: remainder is shifted left by one and takes in the next dividend MSB. Subtract if remainder >= divisor and shift in the quotient bit. Counter increments.
  - After N iterations go to FIX (one cycle).
- FIX (magnitude q is N bits):
  - If sign==0: q > 2^(W-1)-1 -> Max, else +q.
  - If sign==1: q >= 2^(W-1) -> Min, else -q.
  - Rounding is truncation toward zero.
  - Go to DONE.
- DONE:
  - out_valid_o=1 and y_o is held stable until out_ready_i.
  - On the output handshake go to IDLE. No new operand is accepted in the same cycle.
- Timing:
  - Latency from accept edge to out_valid_o: N+1 edges for normal operation, 1 edge for divide-by-zero.
  - Throughput is one result per N+2 cycles minimum.
- in_ready_o=0 in CALC, FIX and DONE. Input changes while not ready are ignored.
- Boundaries:
  - Min/Min = 1.0.
  - Min/(-1 LSB) saturates to Max.
  - 0/x = 0, including a negative divisor; no negative zero exists.
  - Back-pressure in DONE of any length keeps y_o unchanged.

Optional Feature:
- Macro: SEQ_FIXED_DIV_STATUS_EN.
- When defined, adds output status_o[1:0] = {div_by_zero, saturated}.
  - Valid with out_valid_o.
  - Reset value 0.
  - saturated is set whenever FIX clamped the result or div_by_zero forced Min/Max.
  - Both bits are 0 for 0/0.
- When undefined, the port and its logic are absent and behaviour is otherwise identical.

Decomposition:
- config_pkg holds:
  - FixedPointPrecision and the fractional-bit constant.
  - fixed_point_t, FixedPointMin, FixedPointMax.
  - A new typedef div_state_e {IDLE, CALC, FIX, DONE}.
- Sub-module seq_fixed_div_core:
  - Unsigned shift-subtract engine with the counter.
  - Ports: start, dividend, divisor, busy, done, quotient.
- The top level does sign handling, the zero bypass, saturation and the handshake.

Test Plan (W=16, F=8):
- a=0x0300, b=0x0200 -> y=0x0180 (1.5); out_valid_o rises 25 edges after accept.
- a=0xFF00, b=0x0300 -> y=0xFFAB (-85/256, truncated toward zero).
- a=0x7F00, b=0x0001 -> y=0x7FFF. a=0x8000, b=0xFFFF -> y=0x7FFF. a=0x8000, b=0x8000 -> y=0x0100. Under STATUS_EN the saturated bit is set on the first two only.
- b=0: a=0xFF00 -> 0x8000, a=0x0100 -> 0x7FFF, a=0 -> 0x0000, each 1 edge after accept. in_ready_o is low throughout.
- Hold out_ready_i=0 for 10 cycles in DONE -> y_o is stable and in_ready_o=0; in_valid_i pulses are ignored. After release, the next operand is accepted in IDLE.
- Assert rst_ni low at iteration 12 of CALC -> out_valid_o=0 and y_o=0 immediately; no result emerges; the next division is correct.
